// File: rtl/mmio_console.sv
// mmio_console: memory-mapped byte console (TX FIFO + UART serializer) with a sticky tohost exit latch.
// Define MMIO_CONSOLE_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module mmio_console #(
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned DEPTH_LOG2 = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic        write,
  input  logic [3:0]  wmask,
  input  logic [31:0] wdata,
  input  logic [31:0] addr,
  output logic [31:0] rdata,
  output logic        hit,
  output logic        tx,
  output logic        exit,
  output logic [30:0] exit_code,
  output logic [2:0]  o_dbg_state
);

  localparam logic [31:0] ADDR_DATA   = 32'h1000_0000;
  localparam logic [31:0] ADDR_STATUS = 32'h1000_0004;
  localparam logic [31:0] ADDR_TOHOST = 32'h1000_1000;
  localparam int unsigned DEPTH       = 1 << DEPTH_LOG2;

  localparam logic [DEPTH_LOG2-1:0] PTR_ONE     = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE     = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_FULL    = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [15:0]           BAUD_RELOAD = 16'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef MMIO_CONSOLE_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  // Bus handshake: a request is a single cycle with valid=1; there is no back-pressure,
  // hit answers combinationally in that cycle and rdata answers exactly one cycle later.
  logic w_sel_data, w_sel_status, w_sel_tohost;
  logic w_wr, w_rd, w_push, w_pop, w_push_ok, w_drop, w_clr, w_set_exit;
  logic w_empty, w_full, w_baud_done, w_tx;
  logic w_unused;
  logic [31:0] w_status;
  state_t w_state_next;

  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr, r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_overflow;
  logic [31:0]           r_rdata;
  logic                  r_exit;
  logic [30:0]           r_exit_code;
  state_t                r_state;
  logic [15:0]           r_baud;
  logic [2:0]            r_bit_idx;
  logic [7:0]            r_tx_byte;

  assign w_sel_data   = (addr == ADDR_DATA);
  assign w_sel_status = (addr == ADDR_STATUS);
  assign w_sel_tohost = (addr == ADDR_TOHOST);
  assign w_wr         = valid && write;
  assign w_rd         = valid && !write;
  assign hit          = valid && (w_sel_data || w_sel_status || w_sel_tohost);

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CNT_FULL);
  assign w_push     = w_wr && w_sel_data && wmask[0];
  assign w_pop      = (r_state == IDLE) && !w_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign w_push_ok  = w_push && (!w_full || w_pop);
  assign w_drop     = w_push && w_full && !w_pop;
  assign w_clr      = w_wr && w_sel_status && wmask[3] && wdata[31];
  assign w_set_exit = w_wr && w_sel_tohost && wmask[0] && wdata[0] && !r_exit;
  assign w_unused   = ^wmask[2:1];

  assign w_status = {r_overflow, 20'd0, w_empty, w_full, (r_state != IDLE), 1'b0, 7'(r_count)};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
      // A dropping push wins over a clear in the same cycle.
      if (w_drop)     r_overflow <= 1'b1;
      else if (w_clr) r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_push_ok) r_mem[r_wr_ptr] <= wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata     <= '0;
      r_exit      <= 1'b0;
      r_exit_code <= '0;
    end else begin
      r_rdata <= (w_rd && w_sel_status) ? w_status : 32'd0;
      if (w_set_exit) begin
        r_exit      <= 1'b1;
        r_exit_code <= wdata[31:1];
      end
    end
  end

  assign w_baud_done = (r_baud == 16'd0);

  always_comb begin
    w_state_next = r_state;
    w_tx         = 1'b1;
    case (r_state)
      IDLE: begin
        if (!w_empty) w_state_next = START;
      end
      START: begin
        w_tx = 1'b0;
        if (w_baud_done) w_state_next = DATA;
      end
      DATA: begin
        w_tx = r_tx_byte[r_bit_idx];
        if (w_baud_done && (r_bit_idx == 3'd7)) begin
`ifdef MMIO_CONSOLE_PARITY_EN
          w_state_next = PARITY;
`else
          w_state_next = STOP;
`endif
        end
      end
`ifdef MMIO_CONSOLE_PARITY_EN
      PARITY: begin
        w_tx = ^r_tx_byte;
        if (w_baud_done) w_state_next = STOP;
      end
`endif
      STOP: begin
        if (w_baud_done) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_baud    <= 16'd0;
      r_bit_idx <= 3'd0;
      r_tx_byte <= 8'd0;
    end else begin
      r_state <= w_state_next;
      if (r_state == IDLE) begin
        if (w_pop) begin
          r_tx_byte <= r_mem[r_rd_ptr];
          r_baud    <= BAUD_RELOAD;
          r_bit_idx <= 3'd0;
        end
      end else if (w_baud_done) begin
        r_baud <= BAUD_RELOAD;
        if (r_state == DATA) r_bit_idx <= r_bit_idx + 3'd1;
      end else begin
        r_baud <= r_baud - 16'd1;
      end
    end
  end

  // The line is forced idle while reset is held so an aborted frame never leaks a low bit.
  assign tx          = rst | w_tx;
  assign rdata       = r_rdata;
  assign exit        = r_exit;
  assign exit_code   = r_exit_code;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mmio_console.sv
// Bench for mmio_console: bus vector table, per-cycle rdata/hit scoreboard and a cycle-exact TX frame monitor.
`timescale 1ns/1ps
module tb_mmio_console;

  localparam int CLK_DIV    = 4;
  localparam int DEPTH_LOG2 = 3;
`ifdef MMIO_CONSOLE_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FL = NB * CLK_DIV;
  localparam logic [31:0] A_DATA = 32'h1000_0000;
  localparam logic [31:0] A_STAT = 32'h1000_0004;
  localparam logic [31:0] A_HOST = 32'h1000_1000;

  logic        clk = 1'b0;
  logic        rst, valid, write;
  logic [3:0]  wmask;
  logic [31:0] wdata, addr, rdata;
  logic        hit, tx, exit;
  logic [30:0] exit_code;
  logic [2:0]  dbg_state;

  mmio_console #(.CLK_DIV(CLK_DIV), .DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clk(clk), .rst(rst), .valid(valid), .write(write), .wmask(wmask),
    .wdata(wdata), .addr(addr), .rdata(rdata), .hit(hit), .tx(tx),
    .exit(exit), .exit_code(exit_code), .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 clk = ~clk;
  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  tx_q[$];
  int          start_t[$];
  int          drv_cyc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle_io(input logic r, input logic v, input logic wr, input logic [31:0] a,
                          input logic [3:0] m, input logic [31:0] d, input logic eh,
                          input logic [31:0] er);
    @(negedge clk);
    if (exp_q.size() > 0) chk($sformatf("rdata@%0d", cyc_cnt), rdata, exp_q.pop_front());
    rst = r; valid = v; write = wr; addr = a; wmask = m; wdata = d;
    drv_cyc = cyc_cnt;
    exp_q.push_back(r ? 32'h0 : er);
    #1;
    chk($sformatf("hit@%0d", cyc_cnt), hit, eh);
  endtask

  task automatic idle_cyc();
    cycle_io(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic push_byte(input logic [7:0] b);
    cycle_io(1'b0, 1'b1, 1'b1, A_DATA, 4'b0001, {24'hABCDEF, b}, 1'b1, 32'h0);
  endtask

  task automatic rd_status(input logic [31:0] e);
    cycle_io(1'b0, 1'b1, 1'b0, A_STAT, 4'h0, 32'h0, 1'b1, e);
  endtask

  // ---------------- TX monitor: samples every cycle, checks whole frame waveform ----------------
  initial begin : tx_mon
    logic        prev;
    logic        aborted;
    logic [43:0] act;
    logic [43:0] exp;
    logic [7:0]  b;
    logic        bitv;
    prev = 1'b1;
    forever begin
      @(negedge clk); #2;
      if (!rst && prev && !tx) begin
        start_t.push_back(cyc_cnt);
        act = '1;
        aborted = 1'b0;
        act[0] = tx;
        for (int i = 1; i < FL; i++) begin
          @(negedge clk); #2;
          act[i] = tx;
          if (rst) aborted = 1'b1;
        end
        if (!aborted) begin
          n_chk++;
          if (tx_q.size() == 0) begin
            $display("FAIL frame: unexpected frame waveform %0h with nothing queued", act);
          end else begin
            b = tx_q.pop_front();
            exp = '1;
            for (int s = 0; s < NB; s++) begin
              if (s == 0)      bitv = 1'b0;
              else if (s <= 8) bitv = b[s-1];
              else if (s == 9 && NB == 11) bitv = ^b;
              else             bitv = 1'b1;
              for (int k = 0; k < CLK_DIV; k++) exp[s*CLK_DIV + k] = bitv;
            end
            if (act === exp) n_pass++;
            else $display("FAIL frame byte %0h: got waveform %0h expected %0h", b, act, exp);
          end
        end
      end
      prev = tx;
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic        v;
    logic        wr;
    logic [31:0] a;
    logic [3:0]  m;
    logic [31:0] d;
    logic        eh;
    logic [31:0] er;
  } vec_t;

  vec_t        tbl[12];
  logic [7:0]  bv[11];
  int          w0, s0, n_starts, low_cnt;

  initial begin
    rst = 1'b1; valid = 1'b0; write = 1'b0; addr = '0; wmask = '0; wdata = '0;

    tbl[0]  = '{1'b1, 1'b0, A_STAT,        4'h0,    32'h0,         1'b1, 32'h0000_0400};
    tbl[1]  = '{1'b1, 1'b0, A_DATA,        4'h0,    32'h0,         1'b1, 32'h0};
    tbl[2]  = '{1'b1, 1'b0, A_HOST,        4'h0,    32'h0,         1'b1, 32'h0};
    tbl[3]  = '{1'b1, 1'b0, 32'h1000_0008, 4'h0,    32'h0,         1'b0, 32'h0};
    tbl[4]  = '{1'b0, 1'b0, A_STAT,        4'h0,    32'h0,         1'b0, 32'h0};
    tbl[5]  = '{1'b1, 1'b0, 32'h0000_0004, 4'h0,    32'h0,         1'b0, 32'h0};
    tbl[6]  = '{1'b1, 1'b1, A_DATA,        4'b1110, 32'h5555_5555, 1'b1, 32'h0};
    tbl[7]  = '{1'b1, 1'b0, A_STAT,        4'h0,    32'h0,         1'b1, 32'h0000_0400};
    tbl[8]  = '{1'b1, 1'b1, A_HOST,        4'b0001, 32'h0000_0006, 1'b1, 32'h0};
    tbl[9]  = '{1'b1, 1'b1, A_STAT,        4'b1000, 32'h8000_0000, 1'b1, 32'h0};
    tbl[10] = '{1'b1, 1'b1, A_HOST,        4'b1110, 32'h0000_0007, 1'b1, 32'h0};
    tbl[11] = '{1'b1, 1'b0, A_STAT,        4'h0,    32'h0,         1'b1, 32'h0000_0400};

    // Reset, with bus writes that must be ignored.
    cycle_io(1'b1, 1'b1, 1'b1, A_HOST, 4'hF, 32'h0000_0007, 1'b1, 32'h0);
    cycle_io(1'b1, 1'b1, 1'b1, A_DATA, 4'h1, 32'h0000_0055, 1'b1, 32'h0);
    idle_cyc();
    chk("reset_tx", tx, 1'b1);
    chk("reset_exit", exit, 1'b0);
    chk("reset_exit_code", exit_code, 31'h0);

    for (int i = 0; i < 12; i++)
      cycle_io(1'b0, tbl[i].v, tbl[i].wr, tbl[i].a, tbl[i].m, tbl[i].d, tbl[i].eh, tbl[i].er);
    idle_cyc();
    chk("exit_before", exit, 1'b0);
    chk("exit_code_before", exit_code, 31'h0);
    chk("tx_idle", tx, 1'b1);

    // tohost exit latch
    cycle_io(1'b0, 1'b1, 1'b1, A_HOST, 4'b0001, 32'h0000_0007, 1'b1, 32'h0);
    idle_cyc();
    chk("exit_set", exit, 1'b1);
    chk("exit_code_set", exit_code, 31'd3);
    cycle_io(1'b0, 1'b1, 1'b1, A_HOST, 4'b0001, 32'h0000_0009, 1'b1, 32'h0);
    idle_cyc();
    chk("exit_hold", exit, 1'b1);
    chk("exit_code_hold", exit_code, 31'd3);

    // Single byte 0x41: frame timing and busy window.
    start_t.delete();
    push_byte(8'h41);
    tx_q.push_back(8'h41);
    w0 = drv_cyc;
    for (int i = 1; i <= FL + 2; i++) begin
      if (i >= FL) rd_status((i == FL + 2) ? 32'h0000_0400 : 32'h0000_0500);
      else idle_cyc();
    end
    repeat (3) idle_cyc();
    chk("single_frames", start_t.size(), 1);
    if (start_t.size() > 0) chk("single_start_cycle", start_t[0], w0 + 2);
    chk("single_drained", tx_q.size(), 0);

    // Ten back-to-back pushes: overflow, clear, push+pop on full, frame pitch.
    start_t.delete();
    for (int k = 0; k < 11; k++) bv[k] = 8'($urandom_range(0, 255));
    for (int k = 0; k < 10; k++) begin
      push_byte(bv[k]);
      if (k != 9) tx_q.push_back(bv[k]);
    end
    rd_status(32'h8000_0308);
    cycle_io(1'b0, 1'b1, 1'b1, A_STAT, 4'b1000, 32'h8000_0000, 1'b1, 32'h0);
    rd_status(32'h0000_0308);
    for (int rel = 13; rel <= FL + 1; rel++) idle_cyc();
    push_byte(bv[10]);
    tx_q.push_back(bv[10]);
    rd_status(32'h0000_0308);
    repeat (10 * (FL + 1)) idle_cyc();
    rd_status(32'h0000_0400);
    idle_cyc();
    chk("burst_drained", tx_q.size(), 0);
    chk("burst_frames", start_t.size(), 10);
    if (start_t.size() == 10)
      for (int i = 0; i < 9; i++)
        chk($sformatf("pitch%0d", i), start_t[i+1] - start_t[i], FL + 1);

`ifdef MMIO_CONSOLE_PARITY_EN
    push_byte(8'h07);
    tx_q.push_back(8'h07);
    push_byte(8'h03);
    tx_q.push_back(8'h03);
    repeat (2 * (FL + 1) + 4) idle_cyc();
    chk("parity_drained", tx_q.size(), 0);
`endif

    // Reset in the middle of DATA with three bytes still queued.
    for (int k = 0; k < 4; k++) push_byte(8'hC0 + 8'(k));
    for (int rel = 4; rel < 20; rel++) idle_cyc();
    cycle_io(1'b1, 1'b1, 1'b1, A_DATA, 4'b0001, 32'h0000_005A, 1'b1, 32'h0);
    rd_status(32'h0000_0400);
    chk("rst_tx_next", tx, 1'b1);
    chk("rst_exit", exit, 1'b0);
    chk("rst_exit_code", exit_code, 31'h0);
    n_starts = start_t.size();
    low_cnt = 0;
    for (int i = 0; i < 150; i++) begin
      idle_cyc();
      if (tx !== 1'b1) low_cnt++;
    end
    rd_status(32'h0000_0400);
    idle_cyc();
    chk("rst_no_frames", start_t.size(), n_starts);
    chk("rst_tx_low_cycles", low_cnt, 0);

    repeat (2) idle_cyc();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
